// File: rtl/aes_inv_cipher_if.sv
// Request/response bundle for the AES-128 inverse cipher: ciphertext and key in,
// registered plaintext, one-cycle valid pulse and busy flag out.
interface aes_inv_cipher_if;
  logic        start_in;
  logic [31:0] ciphertext0_in;
  logic [31:0] ciphertext1_in;
  logic [31:0] ciphertext2_in;
  logic [31:0] ciphertext3_in;
  logic [31:0] key0_in;
  logic [31:0] key1_in;
  logic [31:0] key2_in;
  logic [31:0] key3_in;
  logic [31:0] plaintext0_out;
  logic [31:0] plaintext1_out;
  logic [31:0] plaintext2_out;
  logic [31:0] plaintext3_out;
  logic        valid_out;
  logic        busy_out;

  modport master (
    output start_in, ciphertext0_in, ciphertext1_in, ciphertext2_in, ciphertext3_in,
    output key0_in, key1_in, key2_in, key3_in,
    input  plaintext0_out, plaintext1_out, plaintext2_out, plaintext3_out,
    input  valid_out, busy_out
  );

  modport slave (
    input  start_in, ciphertext0_in, ciphertext1_in, ciphertext2_in, ciphertext3_in,
    input  key0_in, key1_in, key2_in, key3_in,
    output plaintext0_out, plaintext1_out, plaintext2_out, plaintext3_out,
    output valid_out, busy_out
  );
endinterface

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 decryptor; round keys are walked backward on the fly from round key 10.
// Define AES_INV_KEY_CACHE_EN to cache the last key and its round key 10 (skips KEYEXP on a hit).
package aes_inv_pkg;
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction
endpackage

module aes_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);
  logic [7:0] w_inv;
  assign w_inv = aes_inv_pkg::gf_inv(i_a);
  assign o_s = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
             ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
endmodule

module aes_inv_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);
  logic [7:0] w_aff;
  assign w_aff = {i_a[6:0], i_a[7]} ^ {i_a[4:0], i_a[7:5]} ^ {i_a[1:0], i_a[7:2]} ^ 8'h05;
  assign o_s = aes_inv_pkg::gf_inv(w_aff);
endmodule

module aes_inv_cipher (
  input  logic                   CLK,
  input  logic                   RST,
  aes_inv_cipher_if.slave        bus
);
  typedef enum logic [2:0] {StIdle, StKeyExp, StRound0, StRound1To9, StFinal, StDone} state_e;

  state_e       r_state, w_state_next;
  logic [127:0] r_data, r_key, r_pt;
  logic [3:0]   r_rcnt;

  logic [127:0] w_ct_in, w_key_in, w_start_key;
  logic         w_hit;
  logic [31:0]  w_k0, w_k1, w_k2, w_k3;
  logic [31:0]  w_ik1, w_ik2, w_ik3, w_ik0;
  logic [31:0]  w_n0, w_n1, w_n2, w_n3;
  logic [31:0]  w_sub_in, w_sub_rot, w_sub_out, w_t;
  logic [3:0]   w_rcon_idx;
  logic [127:0] w_fwd_key, w_inv_key;
  logic [127:0] w_isr, w_isb, w_ark, w_imc;

  assign w_ct_in  = {bus.ciphertext0_in, bus.ciphertext1_in, bus.ciphertext2_in,
                     bus.ciphertext3_in};
  assign w_key_in = {bus.key0_in, bus.key1_in, bus.key2_in, bus.key3_in};

  // One shared SubWord serves both the forward and the backward key step.
  assign {w_k0, w_k1, w_k2, w_k3} = r_key;
  assign w_ik3      = w_k3 ^ w_k2;
  assign w_ik2      = w_k2 ^ w_k1;
  assign w_ik1      = w_k1 ^ w_k0;
  assign w_sub_in   = (r_state == StKeyExp) ? w_k3 : w_ik3;
  assign w_sub_rot  = {w_sub_in[23:0], w_sub_in[31:24]};
  assign w_rcon_idx = (r_state == StKeyExp) ? r_rcnt + 4'd1 : r_rcnt;
  assign w_t        = w_sub_out ^ {aes_inv_pkg::rcon(w_rcon_idx), 24'h000000};
  assign w_n0       = w_k0 ^ w_t;
  assign w_n1       = w_k1 ^ w_n0;
  assign w_n2       = w_k2 ^ w_n1;
  assign w_n3       = w_k3 ^ w_n2;
  assign w_fwd_key  = {w_n0, w_n1, w_n2, w_n3};
  assign w_ik0      = w_k0 ^ w_t;
  assign w_inv_key  = {w_ik0, w_ik1, w_ik2, w_ik3};

  for (genvar g = 0; g < 4; g++) begin : g_key_sbox
    aes_sbox u_sbox (
      .i_a (w_sub_rot[31-8*g -: 8]),
      .o_s (w_sub_out[31-8*g -: 8])
    );
  end

  // Byte k sits at [127-8k]; k = 4*column + row. Row r rotates right by r columns.
  always_comb begin
    w_isr = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_isr[127-8*(4*c+r) -: 8] = r_data[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_state_sbox
    aes_inv_sbox u_inv_sbox (
      .i_a (w_isr[127-8*g -: 8]),
      .o_s (w_isb[127-8*g -: 8])
    );
  end

  assign w_ark = w_isb ^ r_key;
  assign w_imc = {aes_inv_pkg::inv_mix_col(w_ark[127:96]), aes_inv_pkg::inv_mix_col(w_ark[95:64]),
                  aes_inv_pkg::inv_mix_col(w_ark[63:32]),  aes_inv_pkg::inv_mix_col(w_ark[31:0])};

`ifdef AES_INV_KEY_CACHE_EN
  logic [127:0] r_cache_key, r_cache_rk10;
  logic         r_cache_vld;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cache_key  <= '0;
      r_cache_rk10 <= '0;
      r_cache_vld  <= 1'b0;
    end else begin
      if (r_state == StIdle && bus.start_in && !w_hit) begin
        r_cache_key <= w_key_in;
        r_cache_vld <= 1'b0;
      end
      if (r_state == StKeyExp && r_rcnt == 4'd9) begin
        r_cache_rk10 <= w_fwd_key;
        r_cache_vld  <= 1'b1;
      end
    end
  end

  assign w_hit       = r_cache_vld && (w_key_in == r_cache_key);
  assign w_start_key = w_hit ? r_cache_rk10 : w_key_in;
`else
  assign w_hit       = 1'b0;
  assign w_start_key = w_key_in;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:      if (bus.start_in) w_state_next = w_hit ? StRound0 : StKeyExp;
      StKeyExp:    if (r_rcnt == 4'd9) w_state_next = StRound0;
      StRound0:    w_state_next = StRound1To9;
      StRound1To9: if (r_rcnt == 4'd1) w_state_next = StFinal;
      StFinal:     w_state_next = StDone;
      StDone:      w_state_next = StIdle;
      default:     w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_data <= '0;
      r_key  <= '0;
      r_pt   <= '0;
      r_rcnt <= 4'd0;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.start_in) begin
            r_data <= w_ct_in;
            r_key  <= w_start_key;
            r_rcnt <= w_hit ? 4'd10 : 4'd0;
          end
        end
        StKeyExp: begin
          r_key  <= w_fwd_key;
          r_rcnt <= r_rcnt + 4'd1;
        end
        StRound0: begin
          r_data <= r_data ^ r_key;
          r_key  <= w_inv_key;
          r_rcnt <= 4'd9;
        end
        StRound1To9: begin
          r_data <= w_imc;
          r_key  <= w_inv_key;
          if (r_rcnt != 4'd1) r_rcnt <= r_rcnt - 4'd1;
        end
        StFinal: begin
          r_pt   <= w_ark;
          r_rcnt <= 4'd0;
        end
        default: ;
      endcase
    end
  end

  assign bus.plaintext0_out = r_pt[127:96];
  assign bus.plaintext1_out = r_pt[95:64];
  assign bus.plaintext2_out = r_pt[63:32];
  assign bus.plaintext3_out = r_pt[31:0];
  assign bus.valid_out      = (r_state == StDone);
  assign bus.busy_out       = (r_state == StKeyExp) || (r_state == StRound0) ||
                              (r_state == StRound1To9) || (r_state == StFinal);
endmodule

// File: tb/tb_aes_inv_cipher.sv
// Directed-vector bench for aes_inv_cipher: known-answer decrypts, latency, start filtering,
// mid-block reset, key cache behaviour and continuous start.
module tb_aes_inv_cipher;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_inv_cipher_if bus_if ();

  aes_inv_cipher dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus_if)
  );

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h5468617473206d79204b756e67204675;
  localparam logic [127:0] C2 = 128'h29c3505f571420f6402299b31a02d73a;
  localparam logic [127:0] P2 = 128'h54776f204f6e65204e696e652054776f;
`ifdef AES_INV_KEY_CACHE_EN
  localparam int HitLat = 11;
`else
  localparam int HitLat = 21;
`endif

  int checks   = 0;
  int failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [127:0] ct, input logic [127:0] key);
    {bus_if.ciphertext0_in, bus_if.ciphertext1_in, bus_if.ciphertext2_in,
     bus_if.ciphertext3_in} = ct;
    {bus_if.key0_in, bus_if.key1_in, bus_if.key2_in, bus_if.key3_in} = key;
  endtask

  function automatic logic [127:0] pt_now();
    return {bus_if.plaintext0_out, bus_if.plaintext1_out, bus_if.plaintext2_out,
            bus_if.plaintext3_out};
  endfunction

  task automatic start_block(input logic [127:0] ct, input logic [127:0] key);
    drive(ct, key);
    bus_if.start_in = 1'b1;
    tick();
    bus_if.start_in = 1'b0;
  endtask

  // Edges counted from the sampling edge until valid_out is seen; 99 means it never came.
  task automatic wait_valid(output int n);
    n = 0;
    while (bus_if.valid_out !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    if (bus_if.valid_out !== 1'b1) n = 99;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.start_in = 1'b0;
    drive(C1, K1);
    tick();
    tick();
    checks++;
    if (bus_if.valid_out !== 1'b0) begin
      failures++; $display("FAIL reset_valid: got %b want 0", bus_if.valid_out);
    end
    checks++;
    if (bus_if.busy_out !== 1'b0) begin
      failures++; $display("FAIL reset_busy: got %b want 0", bus_if.busy_out);
    end
    checks++;
    if (pt_now() !== 128'h0) begin
      failures++; $display("FAIL reset_pt: got %h want 0", pt_now());
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fips();
    int n;
    start_block(C1, K1);
    checks++;
    if (bus_if.busy_out !== 1'b1) begin
      failures++; $display("FAIL fips_busy: got %b want 1", bus_if.busy_out);
    end
    wait_valid(n);
    checks++;
    if (n !== 21) begin
      failures++; $display("FAIL fips_latency: got %0d want 21", n);
    end
    checks++;
    if (pt_now() !== P1) begin
      failures++; $display("FAIL fips_pt: got %h want %h", pt_now(), P1);
    end
    checks++;
    if (bus_if.busy_out !== 1'b0) begin
      failures++; $display("FAIL fips_busy_at_valid: got %b want 0", bus_if.busy_out);
    end
    tick();
    checks++;
    if (bus_if.valid_out !== 1'b0) begin
      failures++; $display("FAIL fips_pulse_width: got %b want 0", bus_if.valid_out);
    end
  endtask

  task automatic test_second_vector();
    int pulses = 0;
    start_block(C2, K2);
    for (int i = 0; i < 40; i++) begin
      if (bus_if.valid_out === 1'b1) pulses++;
      tick();
    end
    checks++;
    if (pulses !== 1) begin
      failures++; $display("FAIL vec2_pulses: got %0d want 1", pulses);
    end
    checks++;
    if (pt_now() !== P2) begin
      failures++; $display("FAIL vec2_pt: got %h want %h", pt_now(), P2);
    end
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    start_block(C1, K1);
    for (int i = 1; i <= 40; i++) begin
      if (i == 5 || i == 12) begin
        drive(C2, K2);
        bus_if.start_in = 1'b1;
      end else begin
        bus_if.start_in = 1'b0;
      end
      tick();
      if (bus_if.valid_out === 1'b1) pulses++;
    end
    bus_if.start_in = 1'b0;
    checks++;
    if (pulses !== 1) begin
      failures++; $display("FAIL ignore_pulses: got %0d want 1", pulses);
    end
    checks++;
    if (pt_now() !== P1) begin
      failures++; $display("FAIL ignore_pt: got %h want %h", pt_now(), P1);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int pulses = 0;
    start_block(C2, K2);
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (bus_if.busy_out !== 1'b0) begin
      failures++; $display("FAIL midrst_busy: got %b want 0", bus_if.busy_out);
    end
    checks++;
    if (pt_now() !== 128'h0) begin
      failures++; $display("FAIL midrst_pt: got %h want 0", pt_now());
    end
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus_if.valid_out === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++; $display("FAIL midrst_no_valid: got %0d pulses want 0", pulses);
    end
    start_block(C1, K1);
    wait_valid(n);
    checks++;
    if (n !== 21) begin
      failures++; $display("FAIL midrst_latency: got %0d want 21", n);
    end
    checks++;
    if (pt_now() !== P1) begin
      failures++; $display("FAIL midrst_pt_after: got %h want %h", pt_now(), P1);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    start_block(C2, K2);
    wait_valid(n);
    checks++;
    if (n !== 21) begin
      failures++; $display("FAIL b2b_first_latency: got %0d want 21", n);
    end
    // A start offered while valid_out is high must be dropped.
    drive(C1, K1);
    bus_if.start_in = 1'b1;
    tick();
    bus_if.start_in = 1'b0;
    tick();
    checks++;
    if (bus_if.busy_out !== 1'b0) begin
      failures++; $display("FAIL done_start_ignored: got busy %b want 0", bus_if.busy_out);
    end
    start_block(C2, K2);
    wait_valid(n);
    checks++;
    if (n !== HitLat) begin
      failures++; $display("FAIL b2b_same_key_latency: got %0d want %0d", n, HitLat);
    end
    checks++;
    if (pt_now() !== P2) begin
      failures++; $display("FAIL b2b_same_key_pt: got %h want %h", pt_now(), P2);
    end
    tick();
    start_block(C1, K1);
    wait_valid(n);
    checks++;
    if (n !== 21) begin
      failures++; $display("FAIL b2b_new_key_latency: got %0d want 21", n);
    end
    checks++;
    if (pt_now() !== P1) begin
      failures++; $display("FAIL b2b_new_key_pt: got %h want %h", pt_now(), P1);
    end
    tick();
  endtask

  task automatic test_hold_start();
    int t[3];
    int np = 0;
    drive(C2, K2);
    bus_if.start_in = 1'b1;
    for (int i = 1; i <= 120 && np < 3; i++) begin
      tick();
      if (bus_if.valid_out === 1'b1) begin
        t[np] = i;
        np++;
      end else if (np > 0) begin
        checks++;
        if (pt_now() !== P2) begin
          failures++; $display("FAIL hold_pt_between: got %h want %h", pt_now(), P2);
        end
      end
    end
    bus_if.start_in = 1'b0;
    checks++;
    if (np !== 3) begin
      failures++; $display("FAIL hold_pulse_count: got %0d want 3", np);
    end else begin
      checks++;
      if (t[1] - t[0] !== HitLat + 2) begin
        failures++; $display("FAIL hold_period_1: got %0d want %0d", t[1] - t[0], HitLat + 2);
      end
      checks++;
      if (t[2] - t[1] !== HitLat + 2) begin
        failures++; $display("FAIL hold_period_2: got %0d want %0d", t[2] - t[1], HitLat + 2);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus_if.start_in = 1'b0;
    drive(128'h0, 128'h0);
    test_reset();
    test_fips();
    test_second_vector();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_hold_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/aes_inv_cipher.md
AES_INV_CIPHER -- requirements
Module: aes_inv_cipher

Interface
REQ-001 The block SHALL have one clock and reset: asynchronous, active-high. Port list:
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 start_in  input  1  single-cycle request to decrypt the inputs sampled on the same edge.
REQ-005 ciphertext0_in..ciphertext3_in  input  32 each  ciphertext block; word0 = bytes 0-3 (column 0), MSB = byte 0.
REQ-006 key0_in..key3_in  input  32 each  AES-128 cipher key (the original key, not round key 10); same word order.
REQ-007 plaintext0_out..plaintext3_out  output  32 each  registered recovered plaintext.
REQ-008 valid_out  output  1  one-cycle pulse; plaintext outputs are valid from this cycle onward.
REQ-009 busy_out  output  1  high from the edge after start acceptance until the edge that raises valid_out.

Function
REQ-010 FSM states SHALL be IDLE, KEYEXP, ROUND0, ROUND1TO9, FINAL, DONE.
REQ-011 IDLE: start_in=1 on an edge SHALL capture ciphertext and key into internal registers and go to KEYEXP.
REQ-012 KEYEXP SHALL run the forward key schedule for exactly 10 cycles, one round key per cycle, ending with round key 10 held.
REQ-013 ROUND0 (1 cycle) SHALL XOR the state with round key 10.
REQ-014 ROUND1TO9 (9 cycles) SHALL apply InvShiftRows, InvSubBytes, AddRoundKey(rk 9 down to 1), then InvMixColumns.
REQ-015 FINAL (1 cycle) SHALL apply InvShiftRows, InvSubBytes, AddRoundKey(rk 0) and load plaintext*_out.
REQ-016 Round keys SHALL be regenerated backward on the fly (inverse key schedule, rcon 0x36 down to 0x01), with no stored table of 11 keys.
REQ-017 Round counter SHALL be 4 bits, counting 1..10 in KEYEXP and 9 down to 1 in ROUND1TO9, with no wrap-around.
REQ-018 DONE SHALL assert valid_out for exactly one cycle and return to IDLE on the next edge.
REQ-019 Latency without cache SHALL be 21 edges: valid_out goes high after the 21st rising edge following the sampling edge.
REQ-020 start_in SHALL be ignored in every state other than IDLE; inputs may change freely while busy_out=1.
REQ-021 start_in in DONE SHALL be ignored; a new block is accepted no earlier than the IDLE cycle that follows.
REQ-022 plaintext*_out SHALL hold their last value until overwritten by the next FINAL.
REQ-023 S-box and inverse S-box lookups SHALL be separate combinational submodules.

Reset
REQ-024 RST=1 SHALL immediately force IDLE, round counter 0, valid_out=0, busy_out=0, plaintext*_out=0, and all internal state and key registers 0.
REQ-025 RST asserted mid-operation SHALL abort the block without producing valid_out; after release the block is idle and accepts start_in on the first edge.

Configuration
REQ-026 Macro AES_INV_KEY_CACHE_EN SHALL enable a cache of the last cipher key and its round key 10, plus a cache-valid flag cleared by RST.
REQ-027 With the macro defined, a start whose key equals the cached key with the flag set SHALL skip KEYEXP and go directly to ROUND0, giving 11-edge latency.
REQ-028 With the macro defined, a key mismatch SHALL run KEYEXP and then update the cache.
REQ-029 Without the macro, there SHALL be no cache logic and every block SHALL take 21 edges.

Verification
REQ-030 Key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d8 6a7b0430 d8cdb780 70b4c55a -> pt 00112233 44556677 8899aabb ccddeeff, 21 edges.
REQ-031 Key 5468617473206d79204b756e67204675, ct 29c3505f 571420f6 402299b3 1a02d73a -> pt 54776f20 4f6e6520 4e696e65 2054776f, single valid pulse.
REQ-032 Pulse start_in at cycles 5 and 12 after the first start -> only the first is decrypted, with exactly one valid_out.
REQ-033 Assert RST at edge 8 of a block, then release and restart with the REQ-030 vector -> no valid_out before restart, correct pt after.
REQ-034 With AES_INV_KEY_CACHE_EN, run REQ-031 twice back-to-back -> second valid_out after 11 edges; a changed key -> 21 edges.
REQ-035 Hold start_in=1 continuously -> a block is accepted only in IDLE, valid_out pulses every 23 cycles, and outputs hold between pulses.
